pulse_analyzer: RTL and testbench

- Downstream of the LED/PGA controller; consumes its per-channel ADC results (IR_ADC_Value, RED_ADC_Value) plus a sample strobe.
- Detects heartbeats on the IR channel with a hysteresis peak/valley tracker.
- Per beat, produces AC (peak-to-peak) and DC (trough) for IR and RED, and the beat interval in samples, for the downstream SpO2/heart-rate computation.

---
 rtl/pulse_pkg.sv | 15 +
 rtl/pulse_analyzer_if.sv | 29 ++
 rtl/pulse_analyzer_minmax_tracker.sv | 42 ++++
 rtl/pulse_analyzer.sv | 170 +++++++++++++++++
 tb/tb_pulse_analyzer.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared state encoding and default parameters for pulse_analyzer
package pulse_pkg;

    typedef enum logic [1:0] {
        ST_ARM     = 2'd0,
        ST_RISING  = 2'd1,
        ST_FALLING = 2'd2
    } state_e;

    localparam int DEF_HYST         = 8;
    localparam int DEF_MIN_INTERVAL = 150;
    localparam int DEF_MAX_INTERVAL = 1500;
    localparam int DEF_CNT_W        = 11;

endpackage

// File: rtl/pulse_analyzer_if.sv
// rtl/pulse_analyzer_if.sv - sample input and beat result bundle for pulse_analyzer
interface pulse_analyzer_if #(
    parameter int CNT_W = 11
);

    logic             Find_setting;
    logic             Sample_valid;
    logic [7:0]       IR_ADC_Value;
    logic [7:0]       RED_ADC_Value;
    logic             Beat_valid;
    logic [7:0]       IR_AC;
    logic [7:0]       IR_DC;
    logic [7:0]       RED_AC;
    logic [7:0]       RED_DC;
    logic [CNT_W-1:0] Beat_interval;
    logic             Timeout;
    logic             Locked;

    modport master (
        output Find_setting, Sample_valid, IR_ADC_Value, RED_ADC_Value,
        input  Beat_valid, IR_AC, IR_DC, RED_AC, RED_DC, Beat_interval, Timeout, Locked
    );

    modport slave (
        input  Find_setting, Sample_valid, IR_ADC_Value, RED_ADC_Value,
        output Beat_valid, IR_AC, IR_DC, RED_AC, RED_DC, Beat_interval, Timeout, Locked
    );

endinterface

// File: rtl/pulse_analyzer_minmax_tracker.sv
// rtl/pulse_analyzer_minmax_tracker.sv - 8-bit running max/min with reload on window restart
module minmax_tracker (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] din,
    output logic [7:0] max_inc,
    output logic [7:0] min_inc
);

    logic [7:0] max_q, max_d;
    logic [7:0] min_q, min_d;

    // max_inc/min_inc already fold in the current sample so a window can close on it
    always_comb begin
        max_inc = (din > max_q) ? din : max_q;
        min_inc = (din < min_q) ? din : min_q;
        max_d   = max_q;
        min_d   = min_q;
        if (en) begin
            if (load) begin
                max_d = din;
                min_d = din;
            end else begin
                max_d = max_inc;
                min_d = min_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_q <= '0;
            min_q <= '0;
        end else begin
            max_q <= max_d;
            min_q <= min_d;
        end
    end

endmodule

// File: rtl/pulse_analyzer.sv
// rtl/pulse_analyzer.sv - IR hysteresis beat detector producing per-beat AC/DC and interval
module pulse_analyzer
    import pulse_pkg::*;
#(
    parameter int HYST         = DEF_HYST,
    parameter int MIN_INTERVAL = DEF_MIN_INTERVAL,
    parameter int MAX_INTERVAL = DEF_MAX_INTERVAL,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                CLK,
    input  logic                rst,
    pulse_analyzer_if.slave     bus
);

    localparam logic [8:0]       HYST9   = 9'(HYST);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_INTERVAL);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INTERVAL);

    state_e           state_q, state_d;
    logic [7:0]       ir_max_q, ir_max_d;
    logic [7:0]       ir_min_q, ir_min_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n;
    logic             first_q, first_d;
    logic             beat_valid_q, beat_valid_d;
    logic             timeout_q, timeout_d;
    logic             locked_q, locked_d;
    logic [7:0]       ir_ac_q, ir_ac_d;
    logic [7:0]       ir_dc_q, ir_dc_d;
    logic [7:0]       red_ac_q, red_ac_d;
    logic [7:0]       red_dc_q, red_dc_d;
    logic [CNT_W-1:0] interval_q, interval_d;

    logic [7:0] s, r;
    logic [7:0] red_max_inc, red_min_inc;
    logic       sample_en, peak_hit, valley_hit, beat_event, timeout_hit, red_load;

    assign s         = bus.IR_ADC_Value;
    assign r         = bus.RED_ADC_Value;
    assign sample_en = bus.Sample_valid && !bus.Find_setting;

    // 9-bit compares so s+HYST and ir_min+HYST cannot wrap near full scale
    always_comb begin
        cnt_n       = (cnt_q >= MAX_CNT) ? MAX_CNT : cnt_q + CNT_W'(1);
        peak_hit    = ({1'b0, s} + HYST9) <= {1'b0, ir_max_q};
        valley_hit  = {1'b0, s} >= ({1'b0, ir_min_q} + HYST9);
        beat_event  = sample_en && (state_q == ST_FALLING) && valley_hit && (cnt_n >= MIN_CNT);
        timeout_hit = sample_en && (state_q != ST_ARM) && (cnt_n == MAX_CNT) && !beat_event;
        red_load    = (state_q == ST_ARM) || beat_event;
    end

    minmax_tracker u_red (
        .clk     (CLK),
        .rst     (rst),
        .en      (sample_en),
        .load    (red_load),
        .din     (r),
        .max_inc (red_max_inc),
        .min_inc (red_min_inc)
    );

    always_comb begin
        state_d      = state_q;
        ir_max_d     = ir_max_q;
        ir_min_d     = ir_min_q;
        cnt_d        = cnt_q;
        first_d      = first_q;
        beat_valid_d = 1'b0;
        timeout_d    = 1'b0;
        locked_d     = locked_q;
        ir_ac_d      = ir_ac_q;
        ir_dc_d      = ir_dc_q;
        red_ac_d     = red_ac_q;
        red_dc_d     = red_dc_q;
        interval_d   = interval_q;

        if (bus.Find_setting) begin
            state_d  = ST_ARM;
            locked_d = 1'b0;
        end else if (bus.Sample_valid) begin
            case (state_q)
                ST_ARM: begin
                    ir_max_d = s;
                    ir_min_d = s;
                    cnt_d    = '0;
                    first_d  = 1'b1;
                    state_d  = ST_RISING;
                end
                ST_RISING: begin
                    cnt_d = cnt_n;
                    if (s > ir_max_q) begin
                        ir_max_d = s;
                    end else if (peak_hit) begin
                        ir_min_d = s;
                        state_d  = ST_FALLING;
                    end
                end
                ST_FALLING: begin
                    cnt_d = cnt_n;
                    if (s < ir_min_q) begin
                        ir_min_d = s;
                    end else if (beat_event) begin
                        state_d  = ST_RISING;
                        ir_max_d = s;
                        cnt_d    = '0;
                        first_d  = 1'b0;
                        // the very first valley after arming only opens the first window
                        if (!first_q) begin
                            beat_valid_d = 1'b1;
                            locked_d     = 1'b1;
                            ir_ac_d      = ir_max_q - ir_min_q;
                            ir_dc_d      = ir_min_q;
                            red_ac_d     = red_max_inc - red_min_inc;
                            red_dc_d     = red_min_inc;
                            interval_d   = cnt_n;
                        end
                    end
                end
                default: state_d = ST_ARM;
            endcase

            if (timeout_hit) begin
                state_d   = ST_ARM;
                timeout_d = 1'b1;
                locked_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q      <= ST_ARM;
            ir_max_q     <= '0;
            ir_min_q     <= '0;
            cnt_q        <= '0;
            first_q      <= 1'b1;
            beat_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            locked_q     <= 1'b0;
            ir_ac_q      <= '0;
            ir_dc_q      <= '0;
            red_ac_q     <= '0;
            red_dc_q     <= '0;
            interval_q   <= '0;
        end else begin
            state_q      <= state_d;
            ir_max_q     <= ir_max_d;
            ir_min_q     <= ir_min_d;
            cnt_q        <= cnt_d;
            first_q      <= first_d;
            beat_valid_q <= beat_valid_d;
            timeout_q    <= timeout_d;
            locked_q     <= locked_d;
            ir_ac_q      <= ir_ac_d;
            ir_dc_q      <= ir_dc_d;
            red_ac_q     <= red_ac_d;
            red_dc_q     <= red_dc_d;
            interval_q   <= interval_d;
        end
    end

    assign bus.Beat_valid    = beat_valid_q;
    assign bus.Timeout       = timeout_q;
    assign bus.Locked        = locked_q;
    assign bus.IR_AC         = ir_ac_q;
    assign bus.IR_DC         = ir_dc_q;
    assign bus.RED_AC        = red_ac_q;
    assign bus.RED_DC        = red_dc_q;
    assign bus.Beat_interval = interval_q;

endmodule

// File: tb/tb_pulse_analyzer.sv
// tb/tb_pulse_analyzer.sv - scoreboard bench for pulse_analyzer
module tb_pulse_analyzer;
    import pulse_pkg::*;

    localparam int CNT_W = 11;
    localparam int NEVER = 32'h7fffffff;
    localparam int K_TRI = 0, K_DITHER = 1, K_NOTCH = 2;

    logic CLK = 1'b0;
    logic rst;

    always #5 CLK = ~CLK;

    pulse_analyzer_if #(.CNT_W(CNT_W)) bus ();

    pulse_analyzer #(
        .HYST         (8),
        .MIN_INTERVAL (10),
        .MAX_INTERVAL (100),
        .CNT_W        (CNT_W)
    ) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [7:0]       ir_ac;
        logic [7:0]       ir_dc;
        logic [7:0]       red_ac;
        logic [7:0]       red_dc;
        logic [CNT_W-1:0] interval;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    vectors       = 0;
    int    miscompares   = 0;
    int    beats_seen    = 0;
    int    timeouts_seen = 0;
    logic  prev_beat     = 1'b0;
    logic  prev_to       = 1'b0;

    function automatic logic [7:0] tri_ir(input int i);
        int p, v;
        p = i % 40;
        v = (p <= 20) ? 50 + 5 * p : 50 + 5 * (40 - p);
        return v[7:0];
    endfunction

    function automatic logic [7:0] tri_red(input int i);
        int p, v;
        p = i % 40;
        v = (p <= 20) ? 80 + 2 * p : 80 + 2 * (40 - p);
        return v[7:0];
    endfunction

    function automatic logic [7:0] wave_ir(input int kind, input int i);
        int p, v;
        p = i % 40;
        v = int'(tri_ir(i));
        if (kind == K_DITHER) begin
            case (p)
                19: v = 150;
                20: v = 146;
                21: v = 150;
                39: v = 50;
                0:  v = 54;
                1:  v = 50;
                default: ;
            endcase
        end else if (kind == K_NOTCH) begin
            case (p)
                0: v = 40;  1: v = 45;  2: v = 50;  3: v = 60;
                4: v = 50;  5: v = 45;  6: v = 40;  7: v = 50;
                8: v = 60;  9: v = 50;  10: v = 44; 11: v = 42;
                38: v = 42; 39: v = 41;
                default: v = 45;
            endcase
        end
        return v[7:0];
    endfunction

    function automatic logic [7:0] wave_red(input int kind, input int i);
        int p, v;
        p = i % 40;
        v = int'(tri_red(i));
        if (kind == K_NOTCH) v = (p == 8) ? 110 : (p == 30) ? 95 : 100;
        return v[7:0];
    endfunction

    function automatic beat_t expected_for(input int kind);
        beat_t e;
        if (kind == K_NOTCH) begin
            e.ir_ac = 8'd20;  e.ir_dc = 8'd40; e.red_ac = 8'd15; e.red_dc = 8'd95;
        end else begin
            e.ir_ac = 8'd100; e.ir_dc = 8'd50; e.red_ac = 8'd40; e.red_dc = 8'd80;
        end
        e.interval = CNT_W'(40);
        return e;
    endfunction

    always @(negedge CLK) begin
        if (bus.Beat_valid === 1'b1) begin
            beats_seen++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_beat got Beat_valid=1 IR_AC=%0d want no beat", bus.IR_AC);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.IR_AC, bus.IR_DC, bus.RED_AC, bus.RED_DC, bus.Beat_interval} !==
                    {mon_e.ir_ac, mon_e.ir_dc, mon_e.red_ac, mon_e.red_dc, mon_e.interval}) begin
                    miscompares++;
                    $display("FAIL beat_fields got ir_ac=%0d ir_dc=%0d red_ac=%0d red_dc=%0d int=%0d want %0d %0d %0d %0d %0d",
                             bus.IR_AC, bus.IR_DC, bus.RED_AC, bus.RED_DC, bus.Beat_interval,
                             mon_e.ir_ac, mon_e.ir_dc, mon_e.red_ac, mon_e.red_dc, mon_e.interval);
                end
            end
            vectors++;
            if (bus.Locked !== 1'b1) begin
                miscompares++;
                $display("FAIL locked_on_beat got %b want 1", bus.Locked);
            end
        end
        if (bus.Timeout === 1'b1) timeouts_seen++;
        if (prev_beat || prev_to) begin
            vectors++;
            if ({bus.Beat_valid, bus.Timeout} !== 2'b00) begin
                miscompares++;
                $display("FAIL pulse_width got beat=%b timeout=%b want 00", bus.Beat_valid, bus.Timeout);
            end
        end
        prev_beat <= bus.Beat_valid;
        prev_to   <= bus.Timeout;
    end

    task automatic drive_sample(input logic [7:0] ir, input logic [7:0] red, input int gap);
        @(negedge CLK);
        bus.Sample_valid  = 1'b1;
        bus.IR_ADC_Value  = ir;
        bus.RED_ADC_Value = red;
        @(negedge CLK);
        bus.Sample_valid  = 1'b0;
        repeat (gap - 1) @(negedge CLK);
    endtask

    task automatic run_wave(input int kind, input int i0, input int i1, input int gap, input int emit_from);
        for (int i = i0; i <= i1; i++) begin
            if (i >= emit_from && (i % 40) == 2) exp_q.push_back(expected_for(kind));
            drive_sample(wave_ir(kind, i), wave_red(kind, i), gap);
        end
        @(negedge CLK);
    endtask

    task automatic do_reset();
        bus.Find_setting  = 1'b0;
        bus.Sample_valid  = 1'b0;
        bus.IR_ADC_Value  = '0;
        bus.RED_ADC_Value = '0;
        rst = 1'b1;
        repeat (2) @(negedge CLK);
        rst = 1'b0;
    endtask

    task automatic check_drain(input string name, input int beats0, input int want);
        vectors++;
        if (beats_seen - beats0 !== want || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_beats got %0d beats (%0d pending) want %0d", name, beats_seen - beats0, exp_q.size(), want);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({bus.Beat_valid, bus.Timeout, bus.Locked} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 000", {bus.Beat_valid, bus.Timeout, bus.Locked});
        end
        vectors++;
        if ({bus.IR_AC, bus.IR_DC, bus.RED_AC, bus.RED_DC, bus.Beat_interval} !== '0) begin
            miscompares++;
            $display("FAIL reset_results got %h want 0", {bus.IR_AC, bus.IR_DC, bus.RED_AC, bus.RED_DC, bus.Beat_interval});
        end
    endtask

    task automatic test_triangle();
        int b0;
        do_reset();
        b0 = beats_seen;
        run_wave(K_TRI, 0, 202, 1, 82);
        check_drain("triangle", b0, 4);
        vectors++;
        if (bus.Locked !== 1'b1) begin
            miscompares++;
            $display("FAIL triangle_locked got %b want 1", bus.Locked);
        end
    endtask

    task automatic test_dither();
        int b0;
        do_reset();
        b0 = beats_seen;
        run_wave(K_DITHER, 0, 162, 1, 82);
        check_drain("dither", b0, 3);
    endtask

    task automatic test_notch();
        int b0;
        do_reset();
        b0 = beats_seen;
        run_wave(K_NOTCH, 0, 162, 1, 82);
        check_drain("notch", b0, 3);
    endtask

    task automatic test_timeout();
        int b0, t0, to_at;
        do_reset();
        run_wave(K_TRI, 0, 82, 1, 82);
        t0    = timeouts_seen;
        to_at = -1;
        for (int k = 1; k <= 100; k++) begin
            drive_sample(8'd100, 8'd100, 1);
            if (bus.Timeout === 1'b1 && to_at < 0) to_at = k;
        end
        @(negedge CLK);
        vectors++;
        if (to_at != 100 || timeouts_seen - t0 != 1) begin
            miscompares++;
            $display("FAIL timeout_pulse got sample %0d count %0d want sample 100 count 1", to_at, timeouts_seen - t0);
        end
        vectors++;
        if (bus.Locked !== 1'b0 || bus.IR_AC !== 8'd100 || bus.Beat_interval !== CNT_W'(40)) begin
            miscompares++;
            $display("FAIL timeout_hold got locked=%b ir_ac=%0d int=%0d want 0 100 40", bus.Locked, bus.IR_AC, bus.Beat_interval);
        end
        b0 = beats_seen;
        run_wave(K_TRI, 0, 82, 1, 82);
        check_drain("rearm", b0, 1);
    endtask

    task automatic test_find_setting();
        int b0, t0;
        do_reset();
        run_wave(K_TRI, 0, 99, 1, 82);
        b0 = beats_seen;
        t0 = timeouts_seen;
        bus.Find_setting = 1'b1;
        run_wave(K_TRI, 100, 119, 1, NEVER);
        bus.Find_setting = 1'b0;
        vectors++;
        if (beats_seen != b0 || timeouts_seen != t0 || bus.Locked !== 1'b0) begin
            miscompares++;
            $display("FAIL find_quiet got beats=%0d timeouts=%0d locked=%b want 0 0 0", beats_seen - b0, timeouts_seen - t0, bus.Locked);
        end
        vectors++;
        if ({bus.IR_AC, bus.IR_DC, bus.RED_AC, bus.RED_DC} !== {8'd100, 8'd50, 8'd40, 8'd80}) begin
            miscompares++;
            $display("FAIL find_hold got %0d %0d %0d %0d want 100 50 40 80", bus.IR_AC, bus.IR_DC, bus.RED_AC, bus.RED_DC);
        end
        b0 = beats_seen;
        run_wave(K_TRI, 0, 82, 1, 82);
        check_drain("after_find", b0, 1);
    endtask

    task automatic test_back_to_back_reset();
        int b0;
        do_reset();
        run_wave(K_TRI, 0, 110, 1, 82);
        @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        vectors++;
        if ({bus.Beat_valid, bus.Timeout, bus.Locked, bus.IR_AC, bus.IR_DC, bus.RED_AC, bus.RED_DC, bus.Beat_interval} !== '0) begin
            miscompares++;
            $display("FAIL midreset_clear got locked=%b ir_ac=%0d int=%0d want all 0", bus.Locked, bus.IR_AC, bus.Beat_interval);
        end
        repeat (5) @(negedge CLK);
        vectors++;
        if ({bus.Beat_valid, bus.Locked, bus.IR_AC, bus.Beat_interval} !== '0) begin
            miscompares++;
            $display("FAIL idle_gap got locked=%b ir_ac=%0d want 0", bus.Locked, bus.IR_AC);
        end
        b0 = beats_seen;
        run_wave(K_TRI, 0, 82, 5, 82);
        check_drain("gapped", b0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish want finish before 1ms");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        test_reset();
        test_triangle();
        test_dither();
        test_notch();
        test_timeout();
        test_find_setting();
        test_back_to_back_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
